// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial add/subtract sequencer driving one shared external full adder, LSB first.
// Latency : start accepted at edge E0, done pulses in the cycle after E(WIDTH); ready again at E(WIDTH+1).
// Backpr. : start is taken only while ready=1 and ignored in RUN/DONE; no stall once a run begins.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, sub, a, b      request handshake, op select (1 = a-b) and operands, sampled on accept
//   ready, busy, done     IDLE / RUN / one-cycle DONE indications (registered-state decode)
//   sum, cout, ovf        last completed result, carry-out (sub: 1 = no borrow), signed overflow
//   fa_a, fa_b, fa_cin    bit operands and carry to the external full adder (0 outside RUN)
//   fa_s, fa_cout         combinational sum and carry returned by the full adder
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Only the upper WIDTH-1 bits of the result shifter are kept; the final
  // sum bit comes straight from the full adder in the last cycle.
  logic [WIDTH-2:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] r_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    // Full result shifter after this cycle's sum bit enters at the MSB.
    r_next  = {fa_s, r_sh_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtract as a + ~b + 1: invert b and seed the carry with 1.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = r_next[WIDTH-1:1];
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = r_next;
          cout_d  = fa_cout;
          // Signed overflow: carry into the MSB differs from carry out of it.
          ovf_d   = carry_q ^ fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign sum    = sum_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign fa_a   = busy & a_sh_q[0];
  assign fa_b   = busy & b_sh_q[0];
  assign fa_cin = busy & carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] sum;
  logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
  );

  // External full adder.
  assign {fa_cout, fa_s} = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_cin};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  int     vectors     = 0;
  int     miscompares = 0;
  int     cyc         = 0;
  int     accepts     = 0;
  int     dones       = 0;
  res_t   exp_q[$];
  int     done_cyc[$];
  logic   fa_bits[$];
  logic [W-1:0] prev_sum = '0;

  // Reference: plain integer arithmetic on the operands as numbers.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t m;
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int r, sr;
    if (!s) begin
      r   = ux + uy;
      sr  = sx + sy;
      m.c = (r > 255);
    end else begin
      r   = ux - uy;
      sr  = sx - sy;
      m.c = (ux >= uy);
    end
    m.s = r[W-1:0];
    m.v = (sr > 127) || (sr < -128);
    return m;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Acceptance monitor: DUT state is still pre-edge here.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n && ready && start) begin
      exp_q.push_back(model(a, b, sub));
      accepts++;
    end
  end

  // Reset drops any in-flight expectation: an aborted op must never complete.
  initial forever begin
    @(negedge rst_n);
    exp_q.delete();
    prev_sum = '0;
  end

  // Output monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("onehot", int'(ready) + int'(busy) + int'(done), 1);
      if (!busy) check("fa_idle_zero", {fa_a, fa_b, fa_cin}, 0);
      else fa_bits.push_back(fa_a);
      if (sum !== prev_sum) check("sum_changed_outside_done", done, 1);
      if (done) begin
        res_t e;
        dones++;
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.c);
          check("ovf", ovf, e.v);
        end
      end
      prev_sum = sum;
    end
  end

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      scramble();
      @(negedge clk);
      k++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic issue_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    wait_ready();
    a = x; b = y; sub = s; start = 1'b1;
    fa_bits.delete();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  task automatic run_dir(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic [W-1:0] es, input logic ec, input logic ev);
    int n;
    issue_op(x, y, s);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      scramble();
      n++;
    end
    check("done_latency", n, 9);
    check("dir_sum", sum, es);
    check("dir_cout", cout, ec);
    check("dir_ovf", ovf, ev);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] seq;
    int base, dbase, cbase, k, seen;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout_ovf", {cout, ovf}, 0);
    check("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases
    run_dir(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    seq = '0;
    for (int i = 0; i < W; i++) if (i < fa_bits.size()) seq[i] = fa_bits[i];
    check("fa_a_seq_len", fa_bits.size(), W);
    check("fa_a_seq", seq, 8'h35);
    run_dir(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_dir(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_dir(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_dir(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // start held high, operands/sub toggled every cycle, 3 back-to-back ops
    wait_ready();
    base  = accepts;
    dbase = dones;
    cbase = done_cyc.size();
    start = 1'b1;
    k = 0;
    while (accepts < base + 3 && k < 60) begin
      scramble();
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    k = 0;
    while (dones < dbase + 3 && k < 40) begin
      scramble();
      @(negedge clk);
      k++;
    end
    check("b2b_accepts", accepts - base, 3);
    check("b2b_dones", dones - dbase, 3);
    if (done_cyc.size() >= cbase + 3) begin
      check("b2b_spacing1", done_cyc[cbase + 1] - done_cyc[cbase], 10);
      check("b2b_spacing2", done_cyc[cbase + 2] - done_cyc[cbase + 1], 10);
    end
    check("b2b_drain", exp_q.size(), 0);

    // Reset during the 4th RUN cycle
    run_dir(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    issue_op(8'h5A, 8'h33, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout_ovf", {cout, ovf}, 0);
    check("abort_fa", {fa_a, fa_b, fa_cin}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    run_dir(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Randomized operations with random idle gaps
    for (int i = 0; i < 40; i++) begin
      int gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        scramble();
      end
      issue_op(W'($urandom), W'($urandom), 1'($urandom));
    end
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    check("accept_done_balance", dones, accepts - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer that time-shares a single external `full_adder` instance to produce a WIDTH-bit sum over WIDTH clock cycles. It latches two operands on a start handshake and feeds one bit pair plus the carry to the full adder per cycle, LSB first. It registers the returned sum bit and carry, then reports the result, the carry-out and the signed overflow with a one-cycle done pulse. It sits between the ALU issue logic and the shared full adder in area-reduced datapath configurations.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only while ready=1
- sub  in  1  sampled with start; 0 = a+b, 1 = a−b
- a  in  WIDTH  operand A, sampled on the accepting edge
- b  in  WIDTH  operand B, sampled on the accepting edge
- ready  out  1  high in IDLE only
- busy  out  1  high in RUN only
- done  out  1  one-cycle pulse in DONE
- sum  out  WIDTH  result; holds the last completed result
- cout  out  1  final carry (subtract: 1 = no borrow, a ≥ b unsigned)
- ovf  out  1  two's-complement overflow of the last result
- fa_a, fa_b, fa_cin  out  1 each  bit operands and carry driven to the full adder
- fa_s, fa_cout  in  1 each  sum and carry returned combinationally by the full adder

## Operation
- FSM states:
  - IDLE→RUN on start=1.
  - RUN→DONE when bit count = WIDTH−1 at a clock edge.
  - DONE→IDLE unconditionally.
  - No other transitions.
- Accept (IDLE, start=1):
  - a_sh ← a
  - b_sh ← sub ? ~b : b
  - carry ← sub
  - cnt ← 0
- RUN, each cycle:
  - Drive fa_a = a_sh[0], fa_b = b_sh[0], fa_cin = carry.
  - At the clock edge, a_sh and b_sh shift right.
  - r_sh shifts right with fa_s entering at the MSB.
  - carry ← fa_cout.
  - cnt ← cnt+1.
- Last RUN cycle (cnt = WIDTH−1):
  - sum ← {fa_s, r_sh[WIDTH−1:1]}
  - cout ← fa_cout
  - ovf ← fa_cin ^ fa_cout
- sum, cout and ovf change only at the RUN→DONE edge. They hold through DONE, IDLE and the next RUN.
- fa_a, fa_b and fa_cin are 0 whenever the state is not RUN.
- start is ignored in RUN and DONE. Operand or sub changes after the accepting edge have no effect.
- Arithmetic is modulo 2^WIDTH. cnt width is clog2(WIDTH).
- Reset (any time, including mid-RUN):
  - state=IDLE
  - ready=1
  - busy=0, done=0
  - sum=0, cout=0, ovf=0
  - fa_*=0
  - All internal registers cleared.
  - An aborted operation never produces done.

## Timing
- Latency:
  - Start accepted at edge E0.
  - RUN occupies the cycles between E0 and E(WIDTH).
  - done=1 in the cycle after E(WIDTH), with sum, cout and ovf already valid.
  - ready returns at E(WIDTH+1).
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously is re-accepted on the first IDLE edge.
- Combinational path: internal regs → fa_a/fa_b/fa_cin → external full adder → fa_s/fa_cout → capture regs. This must close in one cycle.
- ready, busy and done decode from registered state only (glitch-free). Exactly one of ready, busy or done is high at any time after reset.
- Reset assertion clears outputs immediately, without waiting for a clock. Deassertion is synchronised by the integrator.

## Test plan
(WIDTH=8, bench instantiates `full_adder` on the fa_* ports)
- Add a=8'h35, b=8'h4A: sum=8'h7F, cout=0, ovf=0. done is high exactly 9 cycles after the accepting edge. fa_a LSB-first sequence is 1,0,1,0,1,1,0,0.
- Add a=8'hFF, b=8'h01: sum=8'h00, cout=1, ovf=0. Add a=8'h7F, b=8'h01: sum=8'h80, cout=0, ovf=1.
- Subtract a=8'h05, b=8'h07: sum=8'hFE, cout=0, ovf=0. Subtract a=8'h80, b=8'h01: sum=8'h7F, cout=1, ovf=1.
- Operands and sub toggled every cycle during RUN, start held high: the result matches the accepted operands. The second operation starts on the IDLE edge, with no lost or duplicated done.
- Back-to-back: start=1 for 3 operations. Each done is spaced 10 cycles apart. sum holds the previous result until each DONE.
- rst_n pulsed low during the 4th RUN cycle: outputs reset immediately, no done pulse. A following add 8'h10+8'h20 gives 8'h30.
